// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, halt encoding and fetch FSM states.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W  = 12;
  localparam int unsigned CPU_INSTR_W = 9;

  localparam logic [CPU_ADDR_W-1:0]  CPU_RESET_PC   = '0;
  localparam logic [CPU_INSTR_W-1:0] CPU_HALT_INSTR = '1;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: load has priority over increment, otherwise hold.
module fetch_pc
  import cpu_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = CPU_ADDR_W,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_pc,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // Increment wraps naturally modulo 2**ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives ROM address from the PC and registers ROM data
// into a single valid/ready output slot, with redirect flush, stall and halt handling.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH  = CPU_ADDR_W,
  parameter int unsigned             INSTR_WIDTH = CPU_INSTR_W,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  HALT_INSTR  = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  instr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   halted
);

  fetch_state_e r_state, w_state_nxt;

  logic                   r_out_valid, w_out_valid_nxt;
  logic [INSTR_WIDTH-1:0] r_out_instr, w_out_instr_nxt;
  logic [ADDR_WIDTH-1:0]  r_out_pc,    w_out_pc_nxt;
  logic                   r_halted,    w_halted_nxt;

  logic                   w_pc_load;
  logic [ADDR_WIDTH-1:0]  w_pc_load_val;
  logic                   w_pc_inc;
  logic [ADDR_WIDTH-1:0]  w_pc;

  fetch_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_fetch_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pc_load),
    .i_load_pc (w_pc_load_val),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FS_IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  // In RUN: redirect flush beats capture, capture beats stall.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;
    w_halted_nxt    = r_halted;
    w_pc_load       = 1'b0;
    w_pc_load_val   = redirect_pc;
    w_pc_inc        = 1'b0;

    case (r_state)
      FS_IDLE: begin
        if (start) begin
          w_state_nxt = FS_RUN;
        end
      end
      FS_RUN: begin
        if (redirect_valid) begin
          w_pc_load       = 1'b1;
          w_pc_load_val   = redirect_pc;
          w_out_valid_nxt = 1'b0;
        end else if (!r_out_valid || out_ready) begin
          w_out_valid_nxt = 1'b1;
          w_out_instr_nxt = instr_in;
          w_out_pc_nxt    = w_pc;
          if (instr_in == HALT_INSTR) begin
            w_state_nxt  = FS_HALTED;
            w_halted_nxt = 1'b1;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      FS_HALTED: begin
        if (start) begin
          w_state_nxt     = FS_RUN;
          w_pc_load       = 1'b1;
          w_pc_load_val   = RESET_PC;
          w_halted_nxt    = 1'b0;
          w_out_valid_nxt = 1'b0;
        end else if (out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = FS_IDLE;
      end
    endcase
  end

  assign instr_addr = w_pc;
  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_instr;
  assign out_pc     = r_out_pc;
  assign halted     = r_halted;

endmodule
